// File: rtl/framebuffer_pkg.sv
// Shared definitions for the ping-pong frame store.
//   - fb_state_e      : controller FSM state encoding
//   - fb_ram_mode()   : SB_RAM40_4K READ_MODE/WRITE_MODE for a pixel width
//   - fb_tile_count() : number of 4 Kbit tiles needed for one bank
package framebuffer_pkg;

    localparam int FB_TILE_BITS = 4096;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_CLEAR         = 2'd1,
        ST_PENDING       = 2'd2,
        ST_CLEAR_PENDING = 2'd3
    } fb_state_e;

    // 16 -> 256x16, 8 -> 512x8, 4 -> 1024x4, 2/1 -> 2048x2.
    function automatic int fb_ram_mode(input int data_width);
        case (data_width)
            16:      return 0;
            8:       return 1;
            4:       return 2;
            default: return 3;
        endcase
    endfunction

    // ceil(depth * width / 4096); never less than one tile.
    function automatic int fb_tile_count(input int data_width, input int addr_width);
        return ((1 << addr_width) * data_width + FB_TILE_BITS - 1) / FB_TILE_BITS;
    endfunction

endpackage

// File: rtl/pingpong_framebuffer_if.sv
// Loader/scanner-facing bus of the ping-pong frame store.
//   master : drives WrEn/WrAddr/WrData, RdEn/RdAddr, FrameSync, SwapReq, ClearReq
//   slave  : drives RdData, RdValid, SwapAck, Busy, FrontSel
interface pingpong_framebuffer_if #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 11
);
    logic                  WrEn;
    logic [ADDR_WIDTH-1:0] WrAddr;
    logic [DATA_WIDTH-1:0] WrData;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] RdAddr;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdValid;
    logic                  FrameSync;
    logic                  SwapReq;
    logic                  SwapAck;
    logic                  ClearReq;
    logic                  Busy;
    logic                  FrontSel;

    modport master (
        output WrEn, WrAddr, WrData, RdEn, RdAddr, FrameSync, SwapReq, ClearReq,
        input  RdData, RdValid, SwapAck, Busy, FrontSel
    );

    modport slave (
        input  WrEn, WrAddr, WrData, RdEn, RdAddr, FrameSync, SwapReq, ClearReq,
        output RdData, RdValid, SwapAck, Busy, FrontSel
    );
endinterface

// File: rtl/fb_bank.sv
// One frame bank: 2**ADDR_WIDTH x DATA_WIDTH built from 4 Kbit tiles.
// Address high bits pick the tile; each tile has a registered read port and
// a registered tile index steers the output mux. Contents have no reset.
//   clk            : clock
//   we/waddr/wdata : write port
//   re/raddr       : read strobe/address (output updates only when re is high)
//   rdata          : read data, one cycle after re
module fb_bank
    import framebuffer_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int TILES   = fb_tile_count(DATA_WIDTH, ADDR_WIDTH);
    localparam int SEL_W   = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int TILE_AW = ADDR_WIDTH - ((TILES > 1) ? SEL_W : 0);

    logic [DATA_WIDTH-1:0] tile_q [TILES];

    generate
        for (genvar gi = 0; gi < TILES; gi++) begin : g_tile
            logic [DATA_WIDTH-1:0] mem [2**TILE_AW];
            logic [DATA_WIDTH-1:0] q_reg;
            logic                  w_hit;
            logic                  r_hit;

            if (TILES > 1) begin : g_sel
                assign w_hit = (waddr[ADDR_WIDTH-1:TILE_AW] == SEL_W'(gi));
                assign r_hit = (raddr[ADDR_WIDTH-1:TILE_AW] == SEL_W'(gi));
            end else begin : g_one
                assign w_hit = 1'b1;
                assign r_hit = 1'b1;
            end

            always_ff @(posedge clk) begin
                if (we && w_hit)
                    mem[waddr[TILE_AW-1:0]] <= wdata;
                if (re && r_hit)
                    q_reg <= mem[raddr[TILE_AW-1:0]];
            end

            assign tile_q[gi] = q_reg;
        end

        if (TILES > 1) begin : g_mux
            logic [SEL_W-1:0] rsel_reg;
            always_ff @(posedge clk) begin
                if (re)
                    rsel_reg <= raddr[ADDR_WIDTH-1:TILE_AW];
            end
            assign rdata = tile_q[rsel_reg];
        end else begin : g_nomux
            assign rdata = tile_q[0];
        end
    endgenerate
endmodule

// File: rtl/pingpong_framebuffer.sv
// Double-buffered frame store. The loader writes the back bank (~FrontSel),
// the scanner reads the front bank (FrontSel). Banks swap only on FrameSync
// after SwapReq, and never while a hardware zero-fill of the back bank runs.
//   Clock, Reset_n : clock, asynchronous active-low reset
//   bus (slave)    : write/read ports, FrameSync/SwapReq/SwapAck handshake,
//                    ClearReq/Busy clear control, FrontSel status
module pingpong_framebuffer
    import framebuffer_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 11,
    parameter int OUTPUT_REG = 0
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    pingpong_framebuffer_if.slave   bus
);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    fb_state_e             state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cnt_reg;
    logic                  front_sel_reg;
    logic                  swap_ack_reg;
    logic                  busy;
    logic                  commit;

    // ---- FSM: state register ----
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.ClearReq && bus.SwapReq)
                    state_next = ST_CLEAR_PENDING;
                else if (bus.ClearReq)
                    state_next = ST_CLEAR;
                else if (bus.SwapReq)
                    state_next = ST_PENDING;
            end
            ST_CLEAR: begin
                // A request arriving on the last clear word goes straight to PENDING.
                if (cnt_reg == CNT_LAST)
                    state_next = bus.SwapReq ? ST_PENDING : ST_IDLE;
                else if (bus.SwapReq)
                    state_next = ST_CLEAR_PENDING;
            end
            ST_CLEAR_PENDING: begin
                if (cnt_reg == CNT_LAST)
                    state_next = ST_PENDING;
            end
            ST_PENDING: begin
                if (bus.FrameSync)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        busy   = (state_reg == ST_CLEAR) || (state_reg == ST_CLEAR_PENDING);
        commit = (state_reg == ST_PENDING) && bus.FrameSync;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_reg       <= '0;
            front_sel_reg <= 1'b0;
            swap_ack_reg  <= 1'b0;
        end else begin
            swap_ack_reg <= commit;
            if (commit)
                front_sel_reg <= ~front_sel_reg;
            // Counter wraps to 0 on the last word, ready for the next clear.
            cnt_reg <= busy ? cnt_reg + 1'b1 : '0;
        end
    end

    // ---- Write port: clear engine owns it while busy ----
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    always_comb begin
        wr_en   = bus.WrEn;
        wr_addr = bus.WrAddr;
        wr_data = bus.WrData;
        if (busy) begin
            wr_en   = 1'b1;
            wr_addr = cnt_reg;
            wr_data = '0;
        end
    end

    // ---- Banks, steered by FrontSel ----
    logic [1:0]            bank_we;
    logic [1:0]            bank_re;
    logic [DATA_WIDTH-1:0] bank_rdata [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_we[gi] = wr_en   && (front_sel_reg != 1'(gi));
            assign bank_re[gi] = bus.RdEn && (front_sel_reg == 1'(gi));

            fb_bank #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_bank (
                .clk   (Clock),
                .we    (bank_we[gi]),
                .waddr (wr_addr),
                .wdata (wr_data),
                .re    (bank_re[gi]),
                .raddr (bus.RdAddr),
                .rdata (bank_rdata[gi])
            );
        end
    endgenerate

    // ---- Read side ----
    // rd_bank_reg remembers which bank answered the last read so RdData holds
    // across a swap. rd_seen_reg forces RdData to 0 until the first read after
    // reset, since bank outputs are not reset.
    logic                  rd_valid1_reg;
    logic                  rd_bank_reg;
    logic                  rd_seen_reg;
    logic [DATA_WIDTH-1:0] rd_word;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_valid1_reg <= 1'b0;
            rd_bank_reg   <= 1'b0;
            rd_seen_reg   <= 1'b0;
        end else begin
            rd_valid1_reg <= bus.RdEn;
            if (bus.RdEn) begin
                rd_bank_reg <= front_sel_reg;
                rd_seen_reg <= 1'b1;
            end
        end
    end

    assign rd_word = rd_seen_reg ? bank_rdata[rd_bank_reg] : '0;

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] rd_data_reg;
            logic                  rd_valid2_reg;
            always_ff @(posedge Clock or negedge Reset_n) begin
                if (!Reset_n) begin
                    rd_data_reg   <= '0;
                    rd_valid2_reg <= 1'b0;
                end else begin
                    rd_valid2_reg <= rd_valid1_reg;
                    if (rd_valid1_reg)
                        rd_data_reg <= rd_word;
                end
            end
            assign bus.RdData  = rd_data_reg;
            assign bus.RdValid = rd_valid2_reg;
        end else begin : g_noreg
            assign bus.RdData  = rd_word;
            assign bus.RdValid = rd_valid1_reg;
        end
    endgenerate

    assign bus.SwapAck  = swap_ack_reg;
    assign bus.Busy     = busy;
    assign bus.FrontSel = front_sel_reg;
endmodule

// File: doc/pingpong_framebuffer.md
# pingpong_framebuffer

Double-buffered, parametrised frame store for the LED panel pipeline. The block sits between the frame-loading side and the row-scan side, which share one clock. The loader writes into a back bank while the scanner reads a front bank. The banks swap only at a scanner frame boundary, after a handshake. The block also provides a hardware clear of the back bank, so the panel never shows a torn or half-cleared frame.

## Interface
- `DATA_WIDTH`, default 2: pixel word width; legal values are 1, 2, 4, 8 and 16.
- `ADDR_WIDTH`, default 11: per-bank depth is 2**ADDR_WIDTH words.
- `OUTPUT_REG`, default 0: set to 1 to add a read output register; read latency is then 2.

Ports:
- `Clock`  in  1  single clock for all logic.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `WrEn`  in  1  write strobe for the back bank.
- `WrAddr`  in  ADDR_WIDTH  write address.
- `WrData`  in  DATA_WIDTH  write data.
- `RdEn`  in  1  read strobe for the front bank.
- `RdAddr`  in  ADDR_WIDTH  read address.
- `RdData`  out  DATA_WIDTH  read data.
- `RdValid`  out  1  qualifies `RdData`.
- `FrameSync`  in  1  one-cycle pulse from the scanner at end of frame.
- `SwapReq`  in  1  level; loader holds it high until `SwapAck`.
- `SwapAck`  out  1  one-cycle pulse when the swap commits.
- `ClearReq`  in  1  pulse; start zero-fill of the back bank.
- `Busy`  out  1  high while a clear is running.
- `FrontSel`  out  1  index of the current front bank.

## Operation
- There are two banks, each 2**ADDR_WIDTH x DATA_WIDTH. Bank `FrontSel` is read-only to the scanner; bank `~FrontSel` is write-only to the loader.
- Controller FSM states are IDLE, CLEAR, PENDING and CLEAR_PENDING.
- IDLE:
  - `SwapReq` moves the FSM to PENDING.
  - `ClearReq` moves the FSM to CLEAR, with `Busy` high and the clear counter at 0.
  - If `ClearReq` and `SwapReq` arrive in the same cycle, the FSM goes to CLEAR_PENDING.
- CLEAR:
  - Writes 0 to back-bank address `cnt`, one word per cycle.
  - Exits to IDLE after address 2**ADDR_WIDTH-1 is written.
  - A `SwapReq` seen during CLEAR moves the FSM to CLEAR_PENDING.
- CLEAR_PENDING: continues the clear, then goes to PENDING.
- PENDING: on a `FrameSync` cycle, `FrontSel` toggles, `SwapAck` pulses, and the FSM returns to IDLE.
- `WrEn` is ignored while `Busy` is high. The loader gets no error indication.
- `ClearReq` is ignored in CLEAR, CLEAR_PENDING and PENDING.
- `FrameSync` is ignored outside PENDING.
- Reads and writes always target opposite banks, so there is no read/write collision and no bypass path.
- RAM contents are not initialised by reset. Software issues `ClearReq` after reset.

## Timing
- Reset values: `FrontSel`=0, `RdData`=0, `RdValid`=0, `SwapAck`=0, `Busy`=0, FSM=IDLE, clear counter=0.
- Read latency is 1 cycle with OUTPUT_REG=0 and 2 cycles with OUTPUT_REG=1. `RdValid` follows `RdEn` with the same latency. `RdData` holds its value when `RdValid` is low.
- The bank select used for a read is sampled in the `RdEn` cycle. A read issued in the swap-commit cycle returns old-front data.
- Swap: `FrameSync` at edge N while in PENDING makes `FrontSel` and `SwapAck` change at edge N+1. A write issued in the cycle after `SwapAck` targets the new back bank.
- `Busy` rises the cycle after `ClearReq` and lasts exactly 2**ADDR_WIDTH cycles.
- The earliest swap commit is the first `FrameSync` after `Busy` falls.
- If `Reset_n` is asserted mid-clear or mid-pending, the block returns immediately to the reset values. A partial clear is not resumed.

## Structure
- `framebuffer_pkg` holds:
  - the FSM state encoding;
  - a function mapping DATA_WIDTH to the SB_RAM40_4K READ_MODE/WRITE_MODE (16→0, 8→1, 4→2, 2/1→3);
  - the tile count per bank, ceil(2**ADDR_WIDTH*DATA_WIDTH/4096).
- Sub-module `fb_bank`: one single-clock bank built from SB_RAM40_4K tiles, with address high bits selecting the tile and a read mux. It is instantiated twice.
- The write and read enables for each bank are steered by `FrontSel` in the top level.

## Test plan
- Clear, then read-back, with DATA_WIDTH=2 and ADDR_WIDTH=11:
  - Issue `ClearReq` from reset.
  - `Busy` must stay high for 2048 cycles.
  - After swap, reads of addresses 0, 1023 and 2047 must return 0.
- Write and swap:
  - Write 0x3 to address 5 of the back bank and assert `SwapReq`.
  - `FrameSync` at cycle T must give `SwapAck`=1 and `FrontSel`=1 at T+1.
  - A read of address 5 must return 0x3 with `RdValid` one cycle later.
- Swap gating:
  - Hold `SwapReq` with no `FrameSync` for 1000 cycles.
  - `FrontSel` must not change and `SwapAck` must stay 0.
- Clear/swap overlap:
  - Assert `SwapReq` at clear cycle 10 and `FrameSync` at clear cycle 20.
  - The swap must not commit during the clear.
  - The next `FrameSync` after `Busy` falls must commit it.
- Latency with OUTPUT_REG=1 and DATA_WIDTH=16:
  - Issue back-to-back reads.
  - `RdValid` must follow `RdEn` by 2 cycles and the data must match the written pattern.
- Reset mid-clear:
  - Drop `Reset_n` at clear cycle 100.
  - `Busy`, `RdValid`, `SwapAck` and `FrontSel` must go to 0 asynchronously, and the FSM must accept a new `ClearReq`.
